// File: rtl/cv_bus_pkg.sv
// Shared types and limits for the cv_bus serial/bus conversion cells.
package cv_bus_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    STALL = 2'd2
  } cv_deser_state_e;

  localparam int CV_DESER_MAX_WIDTH = 32;

endpackage

// File: rtl/cv_bus_hold_reg.sv
// Output holding register with ready/valid handshake; a load may coincide
// with the drain of the previous word.
module cv_bus_hold_reg #(
  parameter int WIDTH = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             load,
  input  logic [WIDTH-1:0] load_data,
  input  logic             out_rdy,
  output logic [WIDTH-1:0] data,
  output logic             vld,
  output logic             free
);

  logic [WIDTH-1:0] data_d, data_q;
  logic             vld_d, vld_q;

  assign free = !vld_q || out_rdy;
  assign data = data_q;
  assign vld  = vld_q;

  // Next word/valid: a load wins over a drain on the same edge.
  always_comb begin
    data_d = data_q;
    vld_d  = vld_q;
    if (load) begin
      data_d = load_data;
      vld_d  = 1'b1;
    end else if (vld_q && out_rdy) begin
      vld_d  = 1'b0;
    end else begin
      vld_d  = vld_q;
    end
  end

  // Holding register state.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      data_q <= '0;
      vld_q  <= 1'b0;
    end else begin
      data_q <= data_d;
      vld_q  <= vld_d;
    end
  end

endmodule

// File: rtl/cv_bus_deser.sv
// Serial-to-bus deserializer: frames a 1-bit stream into WIDTH-bit words
// and hands them to a ready/valid bus port.
module cv_bus_deser
  import cv_bus_pkg::*;
#(
  parameter int WIDTH     = 2,
  parameter bit MSB_FIRST = 1'b1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in,
  input  logic             in_vld,
  input  logic             in_sof,
  output logic             in_rdy,
  output logic [WIDTH-1:0] out,
  output logic             out_vld,
  input  logic             out_rdy,
  output logic             err
);

  localparam int CNT_W = (WIDTH > 2) ? $clog2(WIDTH) : 1;

  if ((WIDTH < 2) || (WIDTH > CV_DESER_MAX_WIDTH)) begin : g_width_check
    $fatal(1, "cv_bus_deser: WIDTH must be in 2..32");
  end

  cv_deser_state_e  state_d, state_q;
  logic [CNT_W-1:0] cnt_d, cnt_q;
  logic [WIDTH-1:0] sh_d, sh_q;
  logic             err_d, err_q;
  logic [WIDTH-1:0] word_s;
  logic             load_s;
  logic [WIDTH-1:0] load_data_s;
  logic             free_s;
  logic             acc_s;

  function automatic logic [CNT_W-1:0] slot_pos(input logic [CNT_W-1:0] k);
    if (MSB_FIRST) begin
      return CNT_W'(WIDTH - 1) - k;
    end else begin
      return k;
    end
  endfunction

  assign in_rdy = (state_q != STALL);
  assign acc_s  = in_vld && in_rdy;
  assign err    = err_q;

  // Framing FSM: an in_sof restart always takes priority over completion.
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    sh_d        = sh_q;
    err_d       = 1'b0;
    load_s      = 1'b0;
    load_data_s = sh_q;
    word_s      = sh_q;
    case (state_q)
      IDLE: begin
        if (acc_s && in_sof) begin
          sh_d                    = '0;
          sh_d[slot_pos(CNT_W'(0))] = in;
          cnt_d                   = CNT_W'(1);
          state_d                 = SHIFT;
        end else if (acc_s) begin
          err_d = 1'b1;
        end else begin
          state_d = IDLE;
        end
      end
      SHIFT: begin
        word_s[slot_pos(cnt_q)] = in;
        if (acc_s && in_sof) begin
          err_d                   = 1'b1;
          sh_d                    = '0;
          sh_d[slot_pos(CNT_W'(0))] = in;
          cnt_d                   = CNT_W'(1);
        end else if (acc_s && (cnt_q == CNT_W'(WIDTH - 1))) begin
          cnt_d = '0;
          if (free_s) begin
            load_s      = 1'b1;
            load_data_s = word_s;
            state_d     = IDLE;
          end else begin
            sh_d    = word_s;
            state_d = STALL;
          end
        end else if (acc_s) begin
          sh_d  = word_s;
          cnt_d = cnt_q + CNT_W'(1);
        end else begin
          state_d = SHIFT;
        end
      end
      STALL: begin
        if (free_s) begin
          load_s      = 1'b1;
          load_data_s = sh_q;
          state_d     = IDLE;
        end else begin
          state_d = STALL;
        end
      end
      default: begin
        state_d = IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  // FSM, counter, shifter and error-pulse registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      sh_q    <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      sh_q    <= sh_d;
      err_q   <= err_d;
    end
  end

  cv_bus_hold_reg #(.WIDTH(WIDTH)) u_hold (
    .clk       (clk),
    .rst_n     (rst_n),
    .load      (load_s),
    .load_data (load_data_s),
    .out_rdy   (out_rdy),
    .data      (out),
    .vld       (out_vld),
    .free      (free_s)
  );

endmodule

// File: tb/tb_cv_bus_deser.sv
// Scoreboard bench for cv_bus_deser: an MSB-first and an LSB-first instance
// share one stimulus stream; a monitor checks every accepted output word.
module tb_cv_bus_deser;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       in_b, in_vld, in_sof, out_rdy;
  logic       in_rdy1, out_vld1, err1;
  logic [1:0] out1;
  logic       in_rdy0, out_vld0, err0;
  logic [1:0] out0;

  int n_vec = 0;
  int n_bad = 0;
  logic [1:0] q1[$];
  logic [1:0] q0[$];

  always #5 clk = ~clk;

  cv_bus_deser #(.WIDTH(2), .MSB_FIRST(1'b1)) dut1 (
    .clk(clk), .rst_n(rst_n), .in(in_b), .in_vld(in_vld), .in_sof(in_sof),
    .in_rdy(in_rdy1), .out(out1), .out_vld(out_vld1), .out_rdy(out_rdy), .err(err1)
  );

  cv_bus_deser #(.WIDTH(2), .MSB_FIRST(1'b0)) dut0 (
    .clk(clk), .rst_n(rst_n), .in(in_b), .in_vld(in_vld), .in_sof(in_sof),
    .in_rdy(in_rdy0), .out(out0), .out_vld(out_vld0), .out_rdy(out_rdy), .err(err0)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Expected word given in serial order (first bit on the left).
  task automatic expect_word(input logic [1:0] w);
    logic [1:0] r;
    r = {w[0], w[1]};
    q1.push_back(w);
    q0.push_back(r);
  endtask

  task automatic send(input logic b, input logic sof);
    in_b   = b;
    in_vld = 1'b1;
    in_sof = sof;
    @(posedge clk);
    #1;
    in_vld = 1'b0;
    in_sof = 1'b0;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
    end
  endtask

  // Monitor: every handshake must match the head of its queue.
  always @(negedge clk) begin
    if (rst_n) begin
      if (out_vld1 && out_rdy) begin
        if (q1.size() == 0) chk("unexpected_word_msb", {30'd0, out1}, 32'hdead);
        else chk("word_msb", {30'd0, out1}, {30'd0, q1.pop_front()});
      end
      if (out_vld0 && out_rdy) begin
        if (q0.size() == 0) chk("unexpected_word_lsb", {30'd0, out0}, 32'hdead);
        else chk("word_lsb", {30'd0, out0}, {30'd0, q0.pop_front()});
      end
    end
  end

  initial begin
    logic [1:0] words [3];
    words[0] = 2'b10;
    words[1] = 2'b01;
    words[2] = 2'b11;
    rst_n   = 1'b0;
    in_b    = 1'b0;
    in_vld  = 1'b0;
    in_sof  = 1'b0;
    out_rdy = 1'b1;
    #12;
    chk("rst_out_vld", {31'd0, out_vld1}, 32'd0);
    chk("rst_out", {30'd0, out1}, 32'd0);
    chk("rst_in_rdy", {31'd0, in_rdy1}, 32'd1);
    chk("rst_err", {31'd0, err1}, 32'd0);
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    // Basic word 1,0 -> MSB-first 10, LSB-first 01.
    expect_word(2'b10);
    send(1'b1, 1'b1);
    send(1'b0, 1'b0);
    chk("basic_latency_vld", {31'd0, out_vld1}, 32'd1);
    chk("basic_err", {31'd0, err1}, 32'd0);
    chk("lsb_first_out", {30'd0, out0}, 32'd1);
    idle(2);

    // Back-to-back words with out_rdy held high.
    for (int w = 0; w < 3; w++) begin
      expect_word(words[w]);
      chk("b2b_in_rdy", {31'd0, in_rdy1}, 32'd1);
      send(words[w][1], 1'b1);
      chk("b2b_in_rdy", {31'd0, in_rdy1}, 32'd1);
      send(words[w][0], 1'b0);
      chk("b2b_vld", {31'd0, out_vld1}, 32'd1);
      chk("b2b_out", {30'd0, out1}, {30'd0, words[w]});
    end
    idle(3);

    // Backpressure: 11 sits in the output register, 01 stalls in the shifter.
    out_rdy = 1'b0;
    expect_word(2'b11);
    expect_word(2'b01);
    send(1'b1, 1'b1);
    send(1'b1, 1'b0);
    send(1'b0, 1'b1);
    send(1'b1, 1'b0);
    chk("stall_in_rdy", {31'd0, in_rdy1}, 32'd0);
    chk("stall_out_hold", {30'd0, out1}, 32'd3);
    idle(2);
    chk("stall_out_stable", {30'd0, out1}, 32'd3);
    chk("stall_in_rdy_held", {31'd0, in_rdy1}, 32'd0);
    out_rdy = 1'b1;
    idle(1);
    chk("unstall_in_rdy", {31'd0, in_rdy1}, 32'd1);
    chk("unstall_out", {30'd0, out1}, 32'd1);
    chk("unstall_vld", {31'd0, out_vld1}, 32'd1);
    idle(3);

    // Framing errors.
    send(1'b1, 1'b0);
    chk("idle_nosof_err", {31'd0, err1}, 32'd1);
    idle(1);
    chk("err_one_cycle", {31'd0, err1}, 32'd0);
    chk("idle_nosof_no_out", {31'd0, out_vld1}, 32'd0);
    expect_word(2'b01);
    send(1'b1, 1'b1);
    chk("midword_no_err_yet", {31'd0, err1}, 32'd0);
    send(1'b0, 1'b1);
    chk("restart_err", {31'd0, err1}, 32'd1);
    chk("restart_not_complete", {31'd0, out_vld1}, 32'd0);
    send(1'b1, 1'b0);
    chk("restart_err_clear", {31'd0, err1}, 32'd0);
    chk("restart_out", {30'd0, out1}, 32'd1);
    idle(3);

    // Reset while stalled: everything clears without a clock edge.
    out_rdy = 1'b0;
    send(1'b1, 1'b1);
    send(1'b1, 1'b0);
    send(1'b1, 1'b1);
    send(1'b0, 1'b0);
    chk("pre_reset_stall", {31'd0, in_rdy1}, 32'd0);
    #1;
    rst_n = 1'b0;
    #1;
    chk("areset_out_vld", {31'd0, out_vld1}, 32'd0);
    chk("areset_out", {30'd0, out1}, 32'd0);
    chk("areset_in_rdy", {31'd0, in_rdy1}, 32'd1);
    chk("areset_err", {31'd0, err1}, 32'd0);
    @(negedge clk);
    rst_n   = 1'b1;
    out_rdy = 1'b1;
    idle(3);
    chk("post_reset_no_out", {31'd0, out_vld1}, 32'd0);

    for (int i = 0; i < 20 && (q1.size() != 0 || q0.size() != 0); i++) begin
      @(posedge clk);
    end
    chk("queue_msb_drained", q1.size(), 32'd0);
    chk("queue_lsb_drained", q0.size(), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
